// File: rtl/or_tree_pkg.sv
// Shared sizing helpers for radix-R reduction trees (OR today, AND/XOR variants later).
package or_tree_pkg;

    function automatic int unsigned pow_int(input int unsigned base, input int unsigned exp);
        int unsigned result;
        result = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            result = result * base;
        end
        return result;
    endfunction

    // Number of reduction levels; at least one even when width fits in a single group.
    function automatic int unsigned clog_radix(input int unsigned width, input int unsigned radix);
        int unsigned levels;
        int unsigned span;
        levels = 1;
        span   = radix;
        while (span < width) begin
            span   = span * radix;
            levels = levels + 1;
        end
        return levels;
    endfunction

    function automatic int unsigned pad_width(input int unsigned width, input int unsigned radix);
        return pow_int(radix, clog_radix(width, radix));
    endfunction

endpackage

// File: rtl/or_tree_stage.sv
// One registered level of the OR tree: groups of RADIX input bits reduce to one output bit.
module or_tree_stage #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RADIX = 8
) (
    input  logic                             CK,
    input  logic                             RN,
    input  logic                             CE,
    input  logic [IN_W-1:0]                  D,
    output logic [(IN_W+RADIX-1)/RADIX-1:0] Q
);

    localparam int unsigned OUT_W = (IN_W + RADIX - 1) / RADIX;
    localparam int unsigned PAD_W = OUT_W * RADIX;

    logic [PAD_W-1:0] d_pad;
    logic [OUT_W-1:0] q_d;

    always_comb begin
        d_pad           = '0;
        d_pad[IN_W-1:0] = D;
        q_d             = '0;
        for (int g = 0; g < OUT_W; g++) begin
            q_d[g] = |d_pad[g*RADIX +: RADIX];
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            Q <= '0;
        end else if (CE) begin
            Q <= q_d;
        end
    end

endmodule

// File: rtl/or_tree_pipe.sv
// Pipelined wide-OR reduction with valid tracking, clock enable and optional sticky flag.
module or_tree_pipe
    import or_tree_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned RADIX  = 8,
    parameter bit          STICKY = 1'b0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             CE,
    input  logic [WIDTH-1:0] A,
    input  logic             VI,
    input  logic             CLR,
    output logic             Z0,
    output logic             VO,
    output logic             ZS
);

    localparam int unsigned L  = clog_radix(WIDTH, RADIX);
    localparam int unsigned PW = pad_width(WIDTH, RADIX);

    logic [PW-1:0] a_pad;
    logic [PW-1:0] lvl [0:L];

    always_comb begin
        a_pad            = '0;
        a_pad[WIDTH-1:0] = A;
    end

    assign lvl[0] = a_pad;

    for (genvar k = 0; k < L; k++) begin : g_level
        localparam int unsigned IN_W  = PW / pow_int(RADIX, k);
        localparam int unsigned OUT_W = IN_W / RADIX;

        or_tree_stage #(
            .IN_W  (IN_W),
            .RADIX (RADIX)
        ) u_stage (
            .CK (CK),
            .RN (RN),
            .CE (CE),
            .D  (lvl[k][IN_W-1:0]),
            .Q  (lvl[k+1][OUT_W-1:0])
        );

        if (OUT_W < PW) begin : g_fill
            assign lvl[k+1][PW-1:OUT_W] = '0;
        end
    end

    // v_chain[0] is the live input; v_chain[L] is the output-aligned valid.
    logic [L-1:0] v_q;
    logic [L:0]   v_chain;

    assign v_chain = {v_q, VI};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            v_q <= '0;
        end else if (CE) begin
            v_q <= v_chain[L-1:0];
        end
    end

    assign VO = v_chain[L];
    assign Z0 = lvl[L][0];

    // Values about to be loaded into the final stage; the last level's input is exactly RADIX wide.
    logic z0_next;
    logic vo_next;

    assign z0_next = |lvl[L-1][RADIX-1:0];
    assign vo_next = v_chain[L-1];

    if (STICKY) begin : g_sticky
        logic zs_q;

        always_ff @(posedge CK or negedge RN) begin
            if (!RN) begin
                zs_q <= 1'b0;
            end else if (CE) begin
                zs_q <= (zs_q & ~CLR) | (vo_next & z0_next);
            end
        end

        assign ZS = zs_q;
    end else begin : g_no_sticky
        assign ZS = 1'b0;
    end

endmodule

// File: tb/tb_or_tree_pipe.sv
// Randomised and directed bench for or_tree_pipe across several width/radix configurations.
module tb_or_tree_pipe;

    logic        ck  = 1'b0;
    logic        rn  = 1'b1;
    logic        ce  = 1'b1;
    logic        vi  = 1'b0;
    logic        clr = 1'b0;
    logic [63:0] a   = '0;

    always #5 ck = ~ck;

    logic z_main, v_main, s_main;
    logic z_pad, v_pad, s_pad;
    logic z_w1, v_w1, s_w1;
    logic z_w8, v_w8, s_w8;
    logic z_w9, v_w9, s_w9;

    or_tree_pipe #(.WIDTH(64), .RADIX(8), .STICKY(1'b1)) u_main (
        .CK(ck), .RN(rn), .CE(ce), .A(a), .VI(vi), .CLR(clr), .Z0(z_main), .VO(v_main), .ZS(s_main)
    );
    or_tree_pipe #(.WIDTH(50), .RADIX(8), .STICKY(1'b0)) u_pad (
        .CK(ck), .RN(rn), .CE(ce), .A(a[49:0]), .VI(vi), .CLR(clr), .Z0(z_pad), .VO(v_pad),
        .ZS(s_pad)
    );
    or_tree_pipe #(.WIDTH(1), .RADIX(8), .STICKY(1'b0)) u_w1 (
        .CK(ck), .RN(rn), .CE(ce), .A(a[0:0]), .VI(vi), .CLR(clr), .Z0(z_w1), .VO(v_w1), .ZS(s_w1)
    );
    or_tree_pipe #(.WIDTH(8), .RADIX(8), .STICKY(1'b0)) u_w8 (
        .CK(ck), .RN(rn), .CE(ce), .A(a[7:0]), .VI(vi), .CLR(clr), .Z0(z_w8), .VO(v_w8), .ZS(s_w8)
    );
    or_tree_pipe #(.WIDTH(9), .RADIX(8), .STICKY(1'b0)) u_w9 (
        .CK(ck), .RN(rn), .CE(ce), .A(a[8:0]), .VI(vi), .CLR(clr), .Z0(z_w9), .VO(v_w9), .ZS(s_w9)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: history of the last two enabled samples; a DUT of latency L shows sample L-1.
    logic [63:0] ha [0:1];
    logic        hv [0:1];
    logic        zs_m;

    always @(posedge ck or negedge rn) begin
        if (!rn) begin
            ha[0] <= '0;
            ha[1] <= '0;
            hv[0] <= 1'b0;
            hv[1] <= 1'b0;
            zs_m  <= 1'b0;
        end else if (ce) begin
            ha[0] <= a;
            ha[1] <= ha[0];
            hv[0] <= vi;
            hv[1] <= hv[0];
            zs_m  <= (zs_m & ~clr) | (hv[0] & (|ha[0]));
        end
    end

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] m;
        if (w >= 64) m = '1;
        else m = (64'd1 << w) - 64'd1;
        return m;
    endfunction

    function automatic logic exp_z(input int w, input int lat);
        return |(ha[lat-1] & wmask(w));
    endfunction

    function automatic logic exp_v(input int lat);
        return hv[lat-1];
    endfunction

    task automatic tick();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic test_reset();
        a  = '1;
        vi = 1'b1;
        ce = 1'b1;
        #1 rn = 1'b0;
        #1;
        checks++;
        if ({z_main, v_main, s_main} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async got=%b exp=000", {z_main, v_main, s_main});
        end
        tick();
        tick();
        checks++;
        if ({z_main, v_main, s_main, z_w1, v_w1} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=00000", {z_main, v_main, s_main, z_w1, v_w1});
        end
        rn = 1'b1;
        a  = '0;
        vi = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (v_main !== (i >= 2) || z_main !== 1'b0) begin
                failures++;
                $display("FAIL reset_release edge=%0d got_vo=%b got_z0=%b exp_vo=%b exp_z0=0",
                         i, v_main, z_main, (i >= 2));
            end
        end
    endtask

    task automatic test_walk_one();
        ce  = 1'b1;
        clr = 1'b0;
        vi  = 1'b1;
        for (int i = 0; i < 66; i++) begin
            a = (i < 64) ? (64'd1 << i) : 64'd0;
            tick();
            checks++;
            if (z_main !== exp_z(64, 2) || v_main !== exp_v(2)) begin
                failures++;
                $display("FAIL walk_main bit=%0d got=%b%b exp=%b%b", i, z_main, v_main,
                         exp_z(64, 2), exp_v(2));
            end
            checks++;
            if (z_pad !== exp_z(50, 2) || v_pad !== exp_v(2)) begin
                failures++;
                $display("FAIL walk_pad bit=%0d got=%b%b exp=%b%b", i, z_pad, v_pad,
                         exp_z(50, 2), exp_v(2));
            end
        end
    endtask

    task automatic test_ce_stall();
        a  = 64'd1 << 17;
        vi = 1'b1;
        tick();
        ce = 1'b0;
        a  = '0;
        vi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (z_main !== exp_z(64, 2) || v_main !== exp_v(2)) begin
                failures++;
                $display("FAIL ce_frozen cyc=%0d got=%b%b exp=%b%b", i, z_main, v_main,
                         exp_z(64, 2), exp_v(2));
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (z_main !== 1'b1 || v_main !== 1'b1) begin
            failures++;
            $display("FAIL ce_resume got=%b%b exp=11", z_main, v_main);
        end
        tick();
        checks++;
        if (z_main !== 1'b0 || v_main !== 1'b0) begin
            failures++;
            $display("FAIL ce_no_dup got=%b%b exp=00", z_main, v_main);
        end
    endtask

    task automatic test_sticky();
        // Each row: a, vi, clr applied for one enabled edge.
        logic [63:0] sa [0:13];
        logic        sv [0:13];
        logic        sc [0:13];
        sa = '{0, 0, 8, 0, 0, 0, 0, 8, 0, 0, 0, 8, 0, 0};
        sv = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        sc = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            a   = sa[i];
            vi  = sv[i];
            clr = sc[i];
            tick();
            checks++;
            if (s_main !== zs_m || z_main !== exp_z(64, 2) || v_main !== exp_v(2)) begin
                failures++;
                $display("FAIL sticky step=%0d got_zs=%b got_z0=%b got_vo=%b exp=%b%b%b", i,
                         s_main, z_main, v_main, zs_m, exp_z(64, 2), exp_v(2));
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_midstream_reset();
        vi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom} | 64'd1;
            tick();
        end
        #2 rn = 1'b0;
        #1;
        checks++;
        if ({z_main, v_main, s_main, z_pad, v_pad, z_w1, v_w1} !== 7'b0) begin
            failures++;
            $display("FAIL midreset_async got=%b exp=0000000",
                     {z_main, v_main, s_main, z_pad, v_pad, z_w1, v_w1});
        end
        a  = '0;
        vi = 1'b0;
        #1 rn = 1'b1;
        @(negedge ck);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({z_main, v_main, s_main, z_w9, v_w9} !== 5'b0) begin
                failures++;
                $display("FAIL midreset_stale cyc=%0d got=%b exp=00000", i,
                         {z_main, v_main, s_main, z_w9, v_w9});
            end
        end
    endtask

    task automatic test_random();
        int          wtab [0:4];
        int          ltab [0:4];
        logic [4:0]  got_z;
        logic [4:0]  got_v;
        wtab  = '{64, 50, 1, 8, 9};
        ltab  = '{2, 2, 1, 1, 2};
        for (int c = 0; c < 10000; c++) begin
            case ($urandom_range(0, 3))
                0: a = '0;
                1: a = 64'd1 << $urandom_range(0, 63);
                2: a = 64'd1 << $urandom_range(0, 9);
                default: a = {$urandom, $urandom};
            endcase
            vi  = 1'($urandom_range(0, 1));
            ce  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            tick();
            got_z = {z_w9, z_w8, z_w1, z_pad, z_main};
            got_v = {v_w9, v_w8, v_w1, v_pad, v_main};
            for (int d = 0; d < 5; d++) begin
                checks++;
                if (got_z[d] !== exp_z(wtab[d], ltab[d]) || got_v[d] !== exp_v(ltab[d])) begin
                    failures++;
                    $display("FAIL random_w%0d cyc=%0d got=%b%b exp=%b%b", wtab[d], c, got_z[d],
                             got_v[d], exp_z(wtab[d], ltab[d]), exp_v(ltab[d]));
                end
            end
            checks++;
            if (s_main !== zs_m || {s_pad, s_w1, s_w8, s_w9} !== 4'b0) begin
                failures++;
                $display("FAIL random_sticky cyc=%0d got=%b others=%b exp=%b others=0000", c,
                         s_main, {s_pad, s_w1, s_w8, s_w9}, zs_m);
            end
        end
        ce  = 1'b1;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk_one();
        test_ce_stall();
        test_sticky();
        test_midstream_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or_tree_pipe.md
# or_tree_pipe

Parametrised, pipelined wide-OR reduction with a valid qualifier, clock enable and optional sticky output. Successor to the fixed 8-input OR gate macros: any input width, reduced in radix-R levels with one register stage per level for timing closure in wide error/interrupt aggregation paths. Sits between status-bit sources and a single flag consumer, such as an interrupt controller or an error FSM.

## Interface
- WIDTH, 64, number of input bits (≥1)
- RADIX, 8, fan-in of each OR level (2..16)
- STICKY, 0, 1 = ZS latches any asserted result until cleared; 0 = ZS tied 0
- CK  in  1  clock, rising edge
- RN  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; 0 holds every pipeline register, including valid and sticky
- A  in  WIDTH  input bits, sampled when CE=1
- VI  in  1  input valid, sampled with A
- CLR  in  1  synchronous clear of ZS (effective only when CE=1)
- Z0  out  1  OR of all A bits, delayed L cycles
- VO  out  1  VI delayed L cycles, aligned with Z0
- ZS  out  1  sticky flag (STICKY=1 only)

## Operation
- Level count L = ceil(log_RADIX(WIDTH)), minimum 1. WIDTH=64, RADIX=8 → L=2. WIDTH=8 → L=1. WIDTH=1 → L=1.
- Input is zero-padded to RADIX^L bits. Level k ORs groups of RADIX bits from level k-1 and registers the result. The final level is a single bit, which drives Z0.
- Valid path: a shift register of L bits carries VI alongside the data. Z0 is meaningful only while VO=1. Data registers still update when VI=0. No gating is applied to data.
- Sticky (STICKY=1), evaluated when CE=1:
  - next ZS = (ZS & ~CLR) | (VO_next & Z0_next). VO_next and Z0_next are the values being loaded into the final stage this cycle.
  - Simultaneous CLR and a new asserted result: ZS remains/becomes 1, so set wins over clear.
  - CLR with no new asserted result: ZS = 0 next cycle.
- CE=0: all state frozen, and CLR is ignored.
- Reset (RN=0), asynchronous, any time including mid-stream:
  - Z0=0, VO=0, ZS=0, and every internal stage = 0. This takes effect immediately, without waiting for CK.
  - In-flight results are discarded.
  - After RN deasserts, the first valid output appears L enabled cycles after the first sampled VI=1.
- No backpressure. The block accepts one sample per enabled cycle.

## Timing
- Latency: A/VI sampled at enabled edge n appear on Z0/VO after enabled edge n+L-1 (i.e. L register stages). Throughput is 1 per enabled cycle.
- ZS updates on the same edge as the final stage. It reflects a result in the same cycle that VO/Z0 show it.
- Combinational depth per stage is one RADIX-input OR. There is no combinational path from any input to any output.
- Reset release: RN is synchronised externally. The block assumes a deasserting edge clean relative to CK.

## Structure
- Package or_tree_pkg:
  - function clog_radix(width, radix) returning L.
  - function pad_width(width, radix) returning RADIX^L.
  - Shared by this block and any future AND/XOR tree variants.
- Sub-module or_tree_stage, instantiated L times through generate:
  - Parameters IN_W, RADIX.
  - Ports CK, RN, CE, D[IN_W], Q[ceil(IN_W/RADIX)].
  - Contains the registered group-OR.
- The top level holds padding, the valid shift register and the sticky logic.

## Test plan
- Reset/idle: RN=0 with A=all-ones, VI=1 → Z0=VO=ZS=0 immediately. After release, A=0 and VI=1 for 4 cycles → VO=1 from the 2nd enabled edge, Z0=0.
- Latency and single bit (WIDTH=64, RADIX=8): walk a one across A[0]..A[63], one per cycle, with VI=1 → Z0=1 exactly 2 edges after each sample. A=0 samples → Z0=0. Also check padding with WIDTH=50 and bit 49 set → Z0=1.
- CE stall: sample A[17]=1 with VI=1, then CE=0 for 5 cycles → Z0/VO stay frozen. Resume CE=1 → result emerges after the remaining stage, with no duplication or loss.
- Sticky (STICKY=1): a single valid sample with A[3]=1 → ZS=1 and it stays set after A returns to 0. CLR=1 → ZS=0 next edge. CLR on the same edge as a new asserted valid result → ZS=1. An asserted Z0 with VO=0 → ZS unchanged.
- Mid-stream reset: back-to-back valid ones in flight, pulse RN low between edges → outputs drop to 0 asynchronously. No stale result appears after release.
- Degenerate parameters: WIDTH=1 → L=1, latency 1. WIDTH=8, RADIX=8 → L=1. WIDTH=9, RADIX=8 → L=2. Random A/VI/CE/CLR for 10k cycles compared against a reference model.
